// File: rtl/round_pkg.sv
// Shared helpers for the rounding datapath: requester tag sizing and the
// round-to-nearest-even decision.
package round_pkg;

    localparam int DEFAULT_NUM_REQ = 4;

    // Tag width for a pool of n requesters; never narrower than one bit.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic rneRoundUp(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, grants one-hot when
// enabled, and moves the pointer just past each granted requester.
module rr_arbiter
    import round_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int ID_W    = idWidth(NUM_REQ)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            found;
    int              idx;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!found && valid_i[idx]) begin
                found      = 1'b1;
                grant_id_o = ID_W'(idx);
            end
        end
        if (enable_i && found) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end

    assign ptr_d = (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else if (enable_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/trailing_sticky_select.sv
// Splits an MSB-aligned fraction into kept bits, trailing bits and a sticky OR
// of everything below them. Narrow inputs are zero-padded at the LSB end.
module TrailingStickySelect #(
    parameter int IN_WIDTH      = 12,
    parameter int OUT_WIDTH     = 8,
    parameter int TRAILING_BITS = 1
) (
    input  logic [IN_WIDTH-1:0]      data_i,
    output logic [OUT_WIDTH-1:0]     frac_o,
    output logic [TRAILING_BITS-1:0] trail_o,
    output logic                     sticky_o
);

    localparam int PAD_W = OUT_WIDTH + TRAILING_BITS;

    if (IN_WIDTH > PAD_W) begin : g_wide
        assign frac_o   = data_i[IN_WIDTH-1 -: OUT_WIDTH];
        assign trail_o  = data_i[IN_WIDTH-1-OUT_WIDTH -: TRAILING_BITS];
        assign sticky_o = |data_i[IN_WIDTH-1-PAD_W:0];
    end else begin : g_narrow
        logic [PAD_W-1:0] padded;

        // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
        always_comb begin
            padded = '0;
            padded[PAD_W-1 -: IN_WIDTH] = data_i;
        end

        assign frac_o   = padded[PAD_W-1 -: OUT_WIDTH];
        assign trail_o  = padded[TRAILING_BITS-1:0];
        assign sticky_o = 1'b0;
    end

endmodule

// File: rtl/round_rne_arbiter.sv
// Shared two-stage RNE rounding pipe: round-robin intake from NUM_REQ lanes,
// stage 1 holds the raw fraction, stage 2 holds the rounded, tagged result.
module round_rne_arbiter
    import round_pkg::*;
#(
    parameter  int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter  int IN_WIDTH = 12,
    parameter  int FRAC     = 8,
    localparam int ID_W     = idWidth(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          reqValid,
    output logic [NUM_REQ-1:0]          reqReady,
    input  logic [NUM_REQ*IN_WIDTH-1:0] reqData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [FRAC-1:0]             outFrac,
    output logic                        outCarry,
    output logic                        outInexact,
    output logic [ID_W-1:0]             outId
);

    logic                s1_valid_q;
    logic [IN_WIDTH-1:0] s1_data_q;
    logic [ID_W-1:0]     s1_id_q;

    logic                s2_valid_q;
    logic [FRAC-1:0]     s2_frac_q;
    logic                s2_carry_q;
    logic                s2_inexact_q;
    logic [ID_W-1:0]     s2_id_q;

    logic                s2_accept;
    logic                s1_accept;
    logic                arb_enable;
    logic                handshake;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;

    logic [FRAC-1:0]     s1_frac;
    logic [0:0]          s1_guard;
    logic                s1_sticky;
    logic                round_up_d;
    logic [FRAC:0]       sum_d;
    logic                inexact_d;

    // Ready ripples combinationally from outReady back to the requesters.
    assign s2_accept  = !s2_valid_q || outReady;
    assign s1_accept  = !s1_valid_q || s2_accept;
    assign arb_enable = s1_accept && resetn;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock      (clock),
        .resetn     (resetn),
        .valid_i    (reqValid),
        .enable_i   (arb_enable),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign reqReady  = grant;
    assign handshake = |grant;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
        end else if (s1_accept) begin
            s1_valid_q <= handshake;
        end
    end

    // NOTE: payload registers carry no reset; the valid bit alone decides whether they mean anything.
    always_ff @(posedge clock) begin
        if (handshake) begin
            s1_data_q <= reqData[grant_id*IN_WIDTH +: IN_WIDTH];
            s1_id_q   <= grant_id;
        end
    end

    TrailingStickySelect #(
        .IN_WIDTH      (IN_WIDTH),
        .OUT_WIDTH     (FRAC),
        .TRAILING_BITS (1)
    ) u_select (
        .data_i   (s1_data_q),
        .frac_o   (s1_frac),
        .trail_o  (s1_guard),
        .sticky_o (s1_sticky)
    );

    always_comb begin
        round_up_d = rneRoundUp(s1_guard[0], s1_sticky, s1_frac[0]);
        sum_d      = {1'b0, s1_frac} + {{FRAC{1'b0}}, round_up_d};
        inexact_d  = s1_guard[0] | s1_sticky;
    end

    // Output fields are visible ports, so they are cleared on reset as well.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s2_valid_q   <= 1'b0;
            s2_frac_q    <= '0;
            s2_carry_q   <= 1'b0;
            s2_inexact_q <= 1'b0;
            s2_id_q      <= '0;
        end else if (s2_accept) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_frac_q    <= sum_d[FRAC-1:0];
                s2_carry_q   <= sum_d[FRAC];
                s2_inexact_q <= inexact_d;
                s2_id_q      <= s1_id_q;
            end
        end
    end

    assign outValid   = s2_valid_q;
    assign outFrac    = s2_frac_q;
    assign outCarry   = s2_carry_q;
    assign outInexact = s2_inexact_q;
    assign outId      = s2_id_q;

endmodule

// File: tb/tb_round_rne_arbiter.sv
// Scoreboard bench for round_rne_arbiter: per-requester stimulus queues,
// expected results queued at each handshake and compared in order at the output.
module tb_round_rne_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int IN_WIDTH = 12;
    localparam int FRAC     = 8;
    localparam int ID_W     = 2;
    localparam int NVEC     = 12;

    logic                        clock = 1'b0;
    logic                        resetn;
    logic [NUM_REQ-1:0]          reqValid;
    logic [NUM_REQ-1:0]          reqReady;
    logic [NUM_REQ*IN_WIDTH-1:0] reqData;
    logic                        outValid;
    logic                        outReady;
    logic [FRAC-1:0]             outFrac;
    logic                        outCarry;
    logic                        outInexact;
    logic [ID_W-1:0]             outId;

    always #5 clock = ~clock;

    round_rne_arbiter #(.NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .FRAC(FRAC)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqData    (reqData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outFrac    (outFrac),
        .outCarry   (outCarry),
        .outInexact (outInexact),
        .outId      (outId)
    );

    typedef struct {
        logic [IN_WIDTH-1:0] data;
        logic [FRAC-1:0]     frac;
        logic                carry;
        logic                inexact;
    } item_t;

    typedef struct {
        logic [FRAC-1:0] frac;
        logic            carry;
        logic            inexact;
        logic [ID_W-1:0] id;
        int              cyc;
    } exp_t;

    typedef struct {
        int                  req;
        logic [IN_WIDTH-1:0] data;
        logic [FRAC-1:0]     frac;
        logic                carry;
        logic                inexact;
    } vec_t;

    item_t pend [NUM_REQ][$];
    exp_t  sb [$];
    int    hs_log [$];
    int    out_cyc [$];
    vec_t  vecs [NVEC];

    int checks;
    int errors;
    int cycle;
    bit lat_check;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference rounding by integer comparison of the dropped nibble against one half.
    function automatic item_t model(input logic [IN_WIDTH-1:0] d);
        item_t   it;
        int      rem;
        int      kept;
        int      res;
        kept = int'(d) >> (IN_WIDTH - FRAC);
        rem  = int'(d) & ((1 << (IN_WIDTH - FRAC)) - 1);
        res  = kept;
        if (rem > (1 << (IN_WIDTH - FRAC - 1)) || (rem == (1 << (IN_WIDTH - FRAC - 1)) && (kept % 2 == 1)))
            res = kept + 1;
        it.data    = d;
        it.frac    = FRAC'(res % (1 << FRAC));
        it.carry   = (res >= (1 << FRAC));
        it.inexact = (rem != 0);
        return it;
    endfunction

    function automatic int pend_total();
        int n = 0;
        for (int i = 0; i < NUM_REQ; i++) n += pend[i].size();
        return n;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            reqValid[i] = (pend[i].size() > 0);
            reqData[i*IN_WIDTH +: IN_WIDTH] = (pend[i].size() > 0) ? pend[i][0].data : '0;
        end
    endtask

    // One clock: compare outputs and log handshakes mid-cycle, then advance and re-drive.
    task automatic step();
        exp_t  e;
        item_t it;
        @(negedge clock);
        check("ready_onehot", 32'($countones(reqReady) <= 1), 32'd1);
        if (outValid && outReady) begin
            out_cyc.push_back(cycle);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result id %0d frac %0h, expected no result", outId, outFrac);
            end else begin
                e = sb.pop_front();
                check("out_frac", 32'(outFrac), 32'(e.frac));
                check("out_carry", 32'(outCarry), 32'(e.carry));
                check("out_inexact", 32'(outInexact), 32'(e.inexact));
                check("out_id", 32'(outId), 32'(e.id));
                if (lat_check) check("latency", 32'(cycle - e.cyc), 32'd2);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqValid[i] && reqReady[i] && pend[i].size() > 0) begin
                it = pend[i].pop_front();
                e.frac    = it.frac;
                e.carry   = it.carry;
                e.inexact = it.inexact;
                e.id      = ID_W'(i);
                e.cyc     = cycle;
                sb.push_back(e);
                hs_log.push_back(i);
            end
        end
        @(posedge clock);
        cycle++;
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() > 0 || pend_total() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_remaining", 32'(sb.size() + pend_total()), 32'd0);
    endtask

    initial begin
        item_t it;
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        lat_check = 1'b1;

        vecs[0]  = '{0, 12'hAB8, 8'hAC, 1'b0, 1'b1};
        vecs[1]  = '{1, 12'hAA8, 8'hAA, 1'b0, 1'b1};
        vecs[2]  = '{2, 12'hAA0, 8'hAA, 1'b0, 1'b0};
        vecs[3]  = '{3, 12'hFF9, 8'h00, 1'b1, 1'b1};
        vecs[4]  = '{0, 12'hFF8, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{1, 12'hFE8, 8'hFE, 1'b0, 1'b1};
        vecs[6]  = '{2, 12'hAB7, 8'hAB, 1'b0, 1'b1};
        vecs[7]  = '{3, 12'h001, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{0, 12'h00F, 8'h01, 1'b0, 1'b1};
        vecs[9]  = '{1, 12'hFFF, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{2, 12'h7F8, 8'h80, 1'b0, 1'b1};
        vecs[11] = '{3, 12'hFF0, 8'hFF, 1'b0, 1'b0};

        // Reset with a requester already valid: nothing may be granted.
        resetn   = 1'b0;
        outReady = 1'b1;
        reqValid = '0;
        reqData  = '0;
        pend[1].push_back(model(12'h5A3));
        drive();
        repeat (2) begin
            @(posedge clock);
            cycle++;
        end
        @(negedge clock);
        check("reset_ready", 32'(reqReady), 32'd0);
        check("reset_valid", 32'(outValid), 32'd0);
        check("reset_frac", 32'(outFrac), 32'd0);
        check("reset_carry", 32'(outCarry), 32'd0);
        check("reset_inexact", 32'(outInexact), 32'd0);
        check("reset_id", 32'(outId), 32'd0);
        @(posedge clock);
        cycle++;
        #1;
        resetn = 1'b1;
        drive();
        drain(20);

        // Directed rounding vectors, one in flight at a time.
        for (int k = 0; k < NVEC; k++) begin
            it.data    = vecs[k].data;
            it.frac    = vecs[k].frac;
            it.carry   = vecs[k].carry;
            it.inexact = vecs[k].inexact;
            pend[vecs[k].req].push_back(it);
            drive();
            drain(20);
        end

        // All requesters valid: round-robin order and one result per cycle.
        hs_log.delete();
        out_cyc.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NUM_REQ; i++)
                pend[i].push_back(model(IN_WIDTH'($urandom)));
        drive();
        drain(40);
        check("stream_hs_count", 32'(hs_log.size()), 32'd12);
        for (int k = 0; k < hs_log.size(); k++)
            check("stream_rr_order", 32'(hs_log[k]), 32'(k % NUM_REQ));
        check("stream_out_count", 32'(out_cyc.size()), 32'd12);
        if (out_cyc.size() == 12)
            check("stream_throughput", 32'(out_cyc[11] - out_cyc[0]), 32'd11);

        // Output stall: two items fill the pipe, then intake stops and outputs hold.
        lat_check = 1'b0;
        hs_log.delete();
        outReady = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                pend[i].push_back(model(IN_WIDTH'($urandom)));
        drive();
        step();
        step();
        check("stall_valid_a", 32'(outValid), 32'd1);
        if (sb.size() > 0) begin
            check("stall_frac_a", 32'(outFrac), 32'(sb[0].frac));
            check("stall_id_a", 32'(outId), 32'(sb[0].id));
        end
        step();
        check("stall_valid_b", 32'(outValid), 32'd1);
        if (sb.size() > 0) begin
            check("stall_frac_b", 32'(outFrac), 32'(sb[0].frac));
            check("stall_carry_b", 32'(outCarry), 32'(sb[0].carry));
            check("stall_id_b", 32'(outId), 32'(sb[0].id));
        end
        check("stall_ready_zero", 32'(reqReady), 32'd0);
        check("stall_accepted", 32'(hs_log.size()), 32'd2);
        if (hs_log.size() == 2) begin
            check("stall_first_id", 32'(hs_log[0]), 32'd0);
            check("stall_second_id", 32'(hs_log[1]), 32'd1);
        end
        outReady = 1'b1;
        drain(40);
        lat_check = 1'b1;

        // Reset with two items in flight: both dropped, pointer back to requester 0.
        outReady = 1'b0;
        hs_log.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 3; i++)
                pend[i].push_back(model(IN_WIDTH'($urandom)));
        drive();
        step();
        step();
        check("flight_accepted", 32'(hs_log.size()), 32'd2);
        check("flight_valid", 32'(outValid), 32'd1);
        resetn = 1'b0;
        sb.delete();
        @(negedge clock);
        check("midreset_ready", 32'(reqReady), 32'd0);
        @(posedge clock);
        cycle++;
        #1;
        check("midreset_valid", 32'(outValid), 32'd0);
        check("midreset_frac", 32'(outFrac), 32'd0);
        check("midreset_id", 32'(outId), 32'd0);
        resetn   = 1'b1;
        outReady = 1'b1;
        hs_log.delete();
        drive();
        step();
        check("post_reset_hs", 32'(hs_log.size()), 32'd1);
        if (hs_log.size() > 0)
            check("post_reset_grant", 32'(hs_log[0]), 32'd0);
        drain(40);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
